id_ex_stage_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 28 ++
 rtl/load_use_detect.sv | 31 +++
 rtl/id_ex_stage_reg.sv | 184 ++++++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-vector bit positions,
// ALUOp encodings, the x0 index and the bubble control word.
package pipe_pkg;

  localparam int CTRL_W_DEF = 7;

  localparam int CTRL_REGWRITE = 6;
  localparam int CTRL_MEMTOREG = 5;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_ALUOP_HI = 2;
  localparam int CTRL_ALUOP_LO = 1;
  localparam int CTRL_ALUSRC   = 0;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } aluop_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = '0;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the instruction in EX
// and the one waiting in ID.
module load_use_detect
  import pipe_pkg::*;
#(
  parameter int RAW = 5
) (
  input  logic           ex_valid_i,
  input  logic           ex_memread_i,
  input  logic [RAW-1:0] ex_rd_i,
  input  logic           id_valid_i,
  input  logic [RAW-1:0] id_rs1_i,
  input  logic [RAW-1:0] id_rs2_i,
  input  logic           id_rs1_used_i,
  input  logic           id_rs2_used_i,
  output logic           hz_o
);

  logic ex_load;
  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    ex_load = ex_valid_i & ex_memread_i
            & (ex_rd_i != RAW'(REG_ZERO));
    rs1_hit = id_rs1_used_i & (id_rs1_i == ex_rd_i);
    rs2_hit = id_rs2_used_i & (id_rs2_i == ex_rd_i);
    hz_o    = ex_load & id_valid_i & (rs1_hit | rs2_hit);
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with built-in load-use stall and bubble.
// Optional counters enabled by `define HAZARD_STATS_EN.
module id_ex_stage_reg
  import pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RAW    = 5,
  parameter int CTRL_W = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [RAW-1:0]    id_rs1_i,
  input  logic [RAW-1:0]    id_rs2_i,
  input  logic [RAW-1:0]    id_rd_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [9:0]        id_funct_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  output logic              stall_o,
  output logic              IDEX_Valid,
  output logic [RAW-1:0]    IDEX_Rs1,
  output logic [RAW-1:0]    IDEX_Rs2,
  output logic [RAW-1:0]    IDEX_Rd,
  output logic [XLEN-1:0]   IDEX_Rs1Data,
  output logic [XLEN-1:0]   IDEX_Rs2Data,
  output logic [XLEN-1:0]   IDEX_Imm,
  output logic [XLEN-1:0]   IDEX_PC,
  output logic [9:0]        IDEX_Funct,
  output logic [CTRL_W-1:0] IDEX_Ctrl,
  output logic [31:0]       bubble_cnt_o,
  output logic [31:0]       flush_cnt_o
);

  logic              valid_q, valid_d;
  logic [RAW-1:0]    rs1_q, rs1_d;
  logic [RAW-1:0]    rs2_q, rs2_d;
  logic [RAW-1:0]    rd_q, rd_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [9:0]        funct_q, funct_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  logic hz;
  logic load_bubble;
  logic flush_bubble;

  load_use_detect #(
    .RAW (RAW)
  ) u_lud (
    .ex_valid_i    (valid_q),
    .ex_memread_i  (ctrl_q[CTRL_MEMREAD]),
    .ex_rd_i       (rd_q),
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rs1_used_i (id_rs1_used_i),
    .id_rs2_used_i (id_rs2_used_i),
    .hz_o          (hz)
  );

  // Flush outranks the hazard: a squashed instruction needs no replay.
  always_comb begin
    flush_bubble = ~hold_i & flush_i;
    load_bubble  = ~hold_i & ~flush_i & hz;
    stall_o      = load_bubble;
  end

  always_comb begin
    valid_d    = valid_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    funct_d    = funct_q;
    ctrl_d     = ctrl_q;
    if (hold_i) begin
      valid_d = valid_q;
    end else if (flush_bubble || load_bubble) begin
      valid_d    = 1'b0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      pc_d       = '0;
      funct_d    = '0;
      ctrl_d     = CTRL_W'(CTRL_BUBBLE);
    end else begin
      valid_d    = id_valid_i;
      rs1_d      = id_rs1_i;
      rs2_d      = id_rs2_i;
      rd_d       = id_rd_i;
      rs1_data_d = id_rs1_data_i;
      rs2_data_d = id_rs2_data_i;
      imm_d      = id_imm_i;
      pc_d       = id_pc_i;
      funct_d    = id_funct_i;
      ctrl_d     = id_valid_i ? id_ctrl_i
                              : CTRL_W'(CTRL_BUBBLE);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      funct_q    <= '0;
      ctrl_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      funct_q    <= funct_d;
      ctrl_q     <= ctrl_d;
    end
  end

  assign IDEX_Valid   = valid_q;
  assign IDEX_Rs1     = rs1_q;
  assign IDEX_Rs2     = rs2_q;
  assign IDEX_Rd      = rd_q;
  assign IDEX_Rs1Data = rs1_data_q;
  assign IDEX_Rs2Data = rs2_data_q;
  assign IDEX_Imm     = imm_q;
  assign IDEX_PC      = pc_q;
  assign IDEX_Funct   = funct_q;
  assign IDEX_Ctrl    = ctrl_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Counters saturate rather than wrap.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (load_bubble && bubble_cnt_q != CNT_MAX)
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    if (flush_bubble && flush_cnt_q != CNT_MAX)
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bubble_cnt_o = bubble_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;
`else
  assign bubble_cnt_o = '0;
  assign flush_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg; counter expectations follow
// whether HAZARD_STATS_EN is defined.
module tb_id_ex_stage_reg;

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [6:0] C_ADD  = 7'b1000000;
  localparam logic [6:0] C_LOAD = 7'b1110001;

  logic        clk = 1'b0;
  logic        rst_i, hold_i, flush_i, id_valid_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic        id_rs1_used_i, id_rs2_used_i;
  logic [31:0] id_rs1_data_i, id_rs2_data_i, id_imm_i, id_pc_i;
  logic [9:0]  id_funct_i;
  logic [6:0]  id_ctrl_i;
  logic        stall_o, IDEX_Valid;
  logic [4:0]  IDEX_Rs1, IDEX_Rs2, IDEX_Rd;
  logic [31:0] IDEX_Rs1Data, IDEX_Rs2Data, IDEX_Imm, IDEX_PC;
  logic [9:0]  IDEX_Funct;
  logic [6:0]  IDEX_Ctrl;
  logic [31:0] bubble_cnt_o, flush_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .hold_i        (hold_i),
    .flush_i       (flush_i),
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rd_i       (id_rd_i),
    .id_rs1_used_i (id_rs1_used_i),
    .id_rs2_used_i (id_rs2_used_i),
    .id_rs1_data_i (id_rs1_data_i),
    .id_rs2_data_i (id_rs2_data_i),
    .id_imm_i      (id_imm_i),
    .id_pc_i       (id_pc_i),
    .id_funct_i    (id_funct_i),
    .id_ctrl_i     (id_ctrl_i),
    .stall_o       (stall_o),
    .IDEX_Valid    (IDEX_Valid),
    .IDEX_Rs1      (IDEX_Rs1),
    .IDEX_Rs2      (IDEX_Rs2),
    .IDEX_Rd       (IDEX_Rd),
    .IDEX_Rs1Data  (IDEX_Rs1Data),
    .IDEX_Rs2Data  (IDEX_Rs2Data),
    .IDEX_Imm      (IDEX_Imm),
    .IDEX_PC       (IDEX_PC),
    .IDEX_Funct    (IDEX_Funct),
    .IDEX_Ctrl     (IDEX_Ctrl),
    .bubble_cnt_o  (bubble_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic       v,
                       input logic [4:0] rs1,
                       input logic [4:0] rs2,
                       input logic [4:0] rd,
                       input logic       u1,
                       input logic       u2,
                       input logic [6:0] ctrl);
    id_valid_i    = v;
    id_rs1_i      = rs1;
    id_rs2_i      = rs2;
    id_rd_i       = rd;
    id_rs1_used_i = u1;
    id_rs2_used_i = u2;
    id_ctrl_i     = ctrl;
  endtask

  function automatic logic [31:0] cnt(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  initial begin
    rst_i = 1'b1;
    hold_i = 1'b0;
    flush_i = 1'b0;
    drive(1'b1, 5'($urandom), 5'($urandom), 5'($urandom),
          1'b1, 1'b1, 7'($urandom));
    id_rs1_data_i = $urandom;
    id_rs2_data_i = $urandom;
    id_imm_i      = $urandom;
    id_pc_i       = $urandom;
    id_funct_i    = 10'($urandom);
    tick();
    tick();
    check("rst_valid", 32'(IDEX_Valid), 32'd0);
    check("rst_rd",    32'(IDEX_Rd), 32'd0);
    check("rst_ctrl",  32'(IDEX_Ctrl), 32'd0);
    check("rst_data",  IDEX_Rs1Data | IDEX_PC | IDEX_Imm, 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_bcnt",  bubble_cnt_o, 32'd0);
    check("rst_fcnt",  flush_cnt_o, 32'd0);

    // add x3,x1,x2
    rst_i = 1'b0;
    drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, C_ADD);
    id_rs1_data_i = 32'd5;
    id_rs2_data_i = 32'd7;
    id_imm_i      = 32'h10;
    id_pc_i       = 32'h100;
    id_funct_i    = 10'h000;
    tick();
    check("add_rs1",   32'(IDEX_Rs1), 32'd1);
    check("add_rs2",   32'(IDEX_Rs2), 32'd2);
    check("add_rd",    32'(IDEX_Rd), 32'd3);
    check("add_d1",    IDEX_Rs1Data, 32'd5);
    check("add_d2",    IDEX_Rs2Data, 32'd7);
    check("add_pc",    IDEX_PC, 32'h100);
    check("add_valid", 32'(IDEX_Valid), 32'd1);
    check("add_ctrl",  32'(IDEX_Ctrl), 32'(C_ADD));

    // lw x5 then add x6,x5,x1
    drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LOAD);
    check("lw_nostall", 32'(stall_o), 32'd0);
    tick();
    drive(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, C_ADD);
    #1;
    check("lu_stall", 32'(stall_o), 32'd1);
    tick();
    check("lu_bvalid", 32'(IDEX_Valid), 32'd0);
    check("lu_bctrl",  32'(IDEX_Ctrl), 32'd0);
    check("lu_stall0", 32'(stall_o), 32'd0);
    tick();
    check("lu_rd",     32'(IDEX_Rd), 32'd6);
    check("lu_valid",  32'(IDEX_Valid), 32'd1);
    check("lu_bcnt",   bubble_cnt_o, cnt(1));

    // lw x0 then reader of x0
    drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, C_LOAD);
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, C_ADD);
    #1;
    check("x0_nostall", 32'(stall_o), 32'd0);

    // lw x5 then rs2=5 unused
    drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LOAD);
    tick();
    drive(1'b1, 5'd7, 5'd5, 5'd9, 1'b1, 1'b0, C_ADD);
    #1;
    check("unused_nostall", 32'(stall_o), 32'd0);

    // flush beats hazard
    id_rs2_used_i = 1'b1;
    #1;
    check("fl_hz", 32'(stall_o), 32'd1);
    flush_i = 1'b1;
    #1;
    check("fl_stall", 32'(stall_o), 32'd0);
    tick();
    flush_i = 1'b0;
    check("fl_valid", 32'(IDEX_Valid), 32'd0);
    check("fl_ctrl",  32'(IDEX_Ctrl), 32'd0);
    check("fl_rd",    32'(IDEX_Rd), 32'd0);
    check("fl_fcnt",  flush_cnt_o, cnt(1));
    check("fl_bcnt",  bubble_cnt_o, cnt(1));

    // hold with pending load-use on x7
    drive(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, C_LOAD);
    tick();
    drive(1'b1, 5'd7, 5'd2, 5'd10, 1'b1, 1'b1, C_ADD);
    hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_stall", 32'(stall_o), 32'd0);
      tick();
      check("hold_rd",   32'(IDEX_Rd), 32'd7);
      check("hold_ctrl", 32'(IDEX_Ctrl), 32'(C_LOAD));
      check("hold_bcnt", bubble_cnt_o, cnt(1));
      drive(1'b1, 5'(i + 11), 5'd7, 5'(i + 20),
            1'b0, 1'b1, C_ADD);
      id_rs1_data_i = 32'(i + 100);
    end
    drive(1'b1, 5'd7, 5'd2, 5'd10, 1'b1, 1'b1, C_ADD);
    hold_i = 1'b0;
    #1;
    check("rel_stall", 32'(stall_o), 32'd1);
    tick();
    check("rel_bvalid", 32'(IDEX_Valid), 32'd0);
    check("rel_bcnt",   bubble_cnt_o, cnt(2));

    // id_valid low forces ctrl to zero
    drive(1'b0, 5'd3, 5'd4, 5'd12, 1'b1, 1'b1, C_ADD);
    tick();
    check("inv_valid", 32'(IDEX_Valid), 32'd0);
    check("inv_ctrl",  32'(IDEX_Ctrl), 32'd0);
    check("inv_rd",    32'(IDEX_Rd), 32'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
